// File: rtl/forwarding_scoreboard_pkg.sv
// rtl/forwarding_scoreboard_pkg.sv - shared CPU constants and forwarding select encodings
package forwarding_scoreboard_pkg;

    localparam int NREG_DEFAULT   = 32;
    localparam int MAXLAT_DEFAULT = 8;

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_WB  = 2'b01,
        SEL_MEM = 2'b10,
        SEL_LL  = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/forwarding_scoreboard_fwd_select.sv
// rtl/forwarding_scoreboard_fwd_select.sv - per-operand EX forwarding mux select
module fwd_select
    import forwarding_scoreboard_pkg::*;
#(
    parameter  int NREG = NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic [AW-1:0]   ex_rs,
    input  logic            mem_regwrite,
    input  logic [AW-1:0]   mem_rd,
    input  logic            wb_regwrite,
    input  logic [AW-1:0]   wb_rd,
    input  logic [NREG-1:0] ll_ready,
    output logic [1:0]      sel
);

    // Youngest producer wins: MEM, then the LL result bus, then WB, else regfile
    always_comb begin
        sel = SEL_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            sel = SEL_MEM;
        end else if (ll_ready[ex_rs]) begin
            sel = SEL_LL;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - hazard scoreboard with load-use and long-latency tracking
module forwarding_scoreboard
    import forwarding_scoreboard_pkg::*;
#(
    parameter  int NREG   = NREG_DEFAULT,
    parameter  int MAXLAT = MAXLAT_DEFAULT,
    localparam int AW     = $clog2(NREG),
    localparam int LW     = $clog2(MAXLAT + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   id_rs1_i,
    input  logic [AW-1:0]   id_rs2_i,
    input  logic [AW-1:0]   ex_rs1_i,
    input  logic [AW-1:0]   ex_rs2_i,
    input  logic            ex_memread_i,
    input  logic [AW-1:0]   ex_rd_i,
    input  logic            mem_regwrite_i,
    input  logic [AW-1:0]   mem_rd_i,
    input  logic            wb_regwrite_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic            issue_valid_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic [LW-1:0]   issue_lat_i,
    output logic [1:0]      fa_o,
    output logic [1:0]      fb_o,
    output logic            stall_o,
    output logic [NREG-1:0] busy_o
);

    // cnt[r] counts down to the cycle r's LL result is on the bus (cnt == 1)
    logic [LW-1:0]   cnt [NREG];
    logic [LW-1:0]   issue_lat_eff;
    logic [NREG-1:0] ll_ready;
    logic            load_use;
    logic            ll_use;
    logic            issue_use;

    // A zero latency still needs one cycle on the bus; anything longer saturates
    always_comb begin
        issue_lat_eff = issue_lat_i;
        if (issue_lat_i == '0) begin
            issue_lat_eff = LW'(1);
        end else if (issue_lat_i > LW'(MAXLAT)) begin
            issue_lat_eff = LW'(MAXLAT);
        end
    end

    // Countdown per register; a new issue to the same rd replaces the old one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (issue_valid_i && (issue_rd_i == AW'(r))) begin
                    cnt[r] <= issue_lat_eff;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LW'(1);
                end
            end
        end
    end

    // Pending and on-the-bus flags, decoded straight from the counters
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_o[r]   = (cnt[r] != '0);
            ll_ready[r] = (cnt[r] == LW'(1));
        end
    end

    // Stall when ID would reach EX before its producer can be forwarded
    always_comb begin
        load_use  = ex_memread_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
        ll_use    = ((id_rs1_i != '0) && (32'(cnt[id_rs1_i]) >= 32'd3)) ||
                    ((id_rs2_i != '0) && (32'(cnt[id_rs2_i]) >= 32'd3));
        issue_use = issue_valid_i && (issue_rd_i != '0) &&
                    ((issue_rd_i == id_rs1_i) || (issue_rd_i == id_rs2_i)) &&
                    (32'(issue_lat_eff) >= 32'd2);
        stall_o   = load_use || ll_use || issue_use;
    end

    fwd_select #(.NREG(NREG)) u_fwd_a (
        .ex_rs        (ex_rs1_i),
        .mem_regwrite (mem_regwrite_i),
        .mem_rd       (mem_rd_i),
        .wb_regwrite  (wb_regwrite_i),
        .wb_rd        (wb_rd_i),
        .ll_ready     (ll_ready),
        .sel          (fa_o)
    );

    fwd_select #(.NREG(NREG)) u_fwd_b (
        .ex_rs        (ex_rs2_i),
        .mem_regwrite (mem_regwrite_i),
        .mem_rd       (mem_rd_i),
        .wb_regwrite  (wb_regwrite_i),
        .wb_rd        (wb_rd_i),
        .ll_ready     (ll_ready),
        .sel          (fb_o)
    );

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - self-checking bench for forwarding_scoreboard
module tb_forwarding_scoreboard;

    localparam int NREG   = 32;
    localparam int MAXLAT = 8;
    localparam int AW     = 5;
    localparam int LW     = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, issue_rd;
    logic            ex_memread, mem_regwrite, wb_regwrite, issue_valid;
    logic [LW-1:0]   issue_lat;
    logic [1:0]      fa, fb;
    logic            stall;
    logic [NREG-1:0] busy;

    int errors = 0;
    int checks = 0;

    // Reference: absolute cycle at which each register's LL result is on the bus
    int cyc = 0;
    int ready [NREG] = '{default: -1};

    always #5 clk = ~clk;

    forwarding_scoreboard #(.NREG(NREG), .MAXLAT(MAXLAT)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .ex_rs1_i       (ex_rs1),
        .ex_rs2_i       (ex_rs2),
        .ex_memread_i   (ex_memread),
        .ex_rd_i        (ex_rd),
        .mem_regwrite_i (mem_regwrite),
        .mem_rd_i       (mem_rd),
        .wb_regwrite_i  (wb_regwrite),
        .wb_rd_i        (wb_rd),
        .issue_valid_i  (issue_valid),
        .issue_rd_i     (issue_rd),
        .issue_lat_i    (issue_lat),
        .fa_o           (fa),
        .fb_o           (fb),
        .stall_o        (stall),
        .busy_o         (busy)
    );

    function automatic int eff_lat(int l);
        if (l == 0) return 1;
        if (l > MAXLAT) return MAXLAT;
        return l;
    endfunction

    // Cycles left until write-back, counting the bus cycle itself
    function automatic int rem(int r);
        if (r == 0 || ready[r] < cyc) return 0;
        return ready[r] - cyc + 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) ready[i] <= -1;
        end else if (issue_valid && issue_rd != 0) begin
            ready[issue_rd] <= cyc + eff_lat(int'(issue_lat));
        end
        cyc <= cyc + 1;
    end

    function automatic logic [1:0] exp_sel(logic [AW-1:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (rem(int'(rs)) == 1) return 2'b11;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_stall();
        logic lu, ll, si;
        lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        ll = rem(int'(id_rs1)) >= 3 || rem(int'(id_rs2)) >= 3;
        si = issue_valid && issue_rd != 0 && (issue_rd == id_rs1 || issue_rd == id_rs2) &&
             eff_lat(int'(issue_lat)) >= 2;
        return lu || ll || si;
    endfunction

    function automatic logic [NREG-1:0] exp_busy();
        logic [NREG-1:0] b;
        for (int r = 0; r < NREG; r++) b[r] = (rem(r) != 0);
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        mem_rd = '0; wb_rd = '0; issue_rd = '0; issue_lat = '0;
        ex_memread = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0; issue_valid = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rd, input int lat);
        issue_valid = 1'b1;
        issue_rd    = AW'(rd);
        issue_lat   = LW'(lat);
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_in_reset", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_fa", 64'(fa), 64'd0);
        check("reset_fb", 64'(fb), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);

        // MEM over WB, then WB alone
        next(); clear_inputs();
        mem_regwrite = 1'b1; mem_rd = 5; wb_regwrite = 1'b1; wb_rd = 5; ex_rs1 = 5;
        @(negedge clk);
        check("fa_mem_prio", 64'(fa), 64'd2);
        check("fb_untouched", 64'(fb), 64'd0);
        mem_regwrite = 1'b0;
        #1;
        check("fa_wb", 64'(fa), 64'd1);

        // Load-use bubble of exactly one cycle
        next(); clear_inputs();
        ex_memread = 1'b1; ex_rd = 7; id_rs2 = 7;
        @(negedge clk);
        check("load_use_stall", 64'(stall), 64'd1);
        next(); clear_inputs(); id_rs2 = 7;
        @(negedge clk);
        check("load_use_release", 64'(stall), 64'd0);
        next(); clear_inputs(); ex_memread = 1'b1; ex_rd = 7;
        @(negedge clk);
        check("load_use_x0", 64'(stall), 64'd0);

        // LL latency 4 to x9
        next(); clear_inputs(); issue(9, 4);
        @(negedge clk);
        check("ll_issue_no_consumer", 64'(stall), 64'd0);
        next(); clear_inputs(); id_rs1 = 9;
        @(negedge clk);
        check("ll_stall_c1", 64'(stall), 64'd1);
        check("ll_busy9", 64'(busy[9]), 64'd1);
        next();
        @(negedge clk);
        check("ll_stall_c2", 64'(stall), 64'd1);
        next();
        @(negedge clk);
        check("ll_stall_cnt2", 64'(stall), 64'd0);
        next(); clear_inputs(); ex_rs1 = 9;
        @(negedge clk);
        check("ll_fa_bus", 64'(fa), 64'd3);
        check("ll_busy9_bus", 64'(busy[9]), 64'd1);
        next();
        @(negedge clk);
        check("ll_busy9_done", 64'(busy[9]), 64'd0);
        check("ll_fa_done", 64'(fa), 64'd0);

        // Same-cycle issue with latency 1 and 0 never stalls
        next(); clear_inputs(); issue(6, 0); id_rs1 = 6;
        @(negedge clk);
        check("issue_lat0_nostall", 64'(stall), 64'd0);
        next(); clear_inputs(); ex_rs1 = 6;
        @(negedge clk);
        check("issue_lat0_fa", 64'(fa), 64'd3);

        // WAW: newer short issue replaces older long one
        next(); clear_inputs(); issue(3, 5);
        next(); clear_inputs();
        next(); issue(3, 1);
        next(); clear_inputs(); ex_rs2 = 3;
        @(negedge clk);
        check("waw_fb_bus", 64'(fb), 64'd3);
        check("waw_busy3", 64'(busy[3]), 64'd1);
        next();
        @(negedge clk);
        check("waw_busy3_done", 64'(busy[3]), 64'd0);
        check("waw_fb_done", 64'(fb), 64'd0);

        // Issue to x0 is ignored
        next(); clear_inputs(); issue(0, 6);
        @(negedge clk);
        check("x0_issue_stall", 64'(stall), 64'd0);
        next(); clear_inputs();
        @(negedge clk);
        check("x0_issue_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-countdown
        next(); clear_inputs(); issue(4, 4);
        next(); clear_inputs();
        next(); ex_rs1 = 4;
        @(negedge clk);
        check("async_pre_busy4", 64'(busy[4]), 64'd1);
        rst = 1'b1;
        #1;
        check("async_busy_drop", 64'(busy), 64'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next();
            @(negedge clk);
            check("async_no_ll", 64'(fa), 64'd0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            next();
            id_rs1       = AW'($urandom_range(0, 7));
            id_rs2       = AW'($urandom_range(0, 7));
            ex_rs1       = AW'($urandom_range(0, 7));
            ex_rs2       = AW'($urandom_range(0, 7));
            ex_rd        = AW'($urandom_range(0, 7));
            mem_rd       = AW'($urandom_range(0, 7));
            wb_rd        = AW'($urandom_range(0, 7));
            issue_rd     = AW'($urandom_range(0, 7));
            issue_lat    = LW'($urandom_range(0, 15));
            ex_memread   = ($urandom_range(0, 3) == 0);
            mem_regwrite = ($urandom_range(0, 2) == 0);
            wb_regwrite  = ($urandom_range(0, 1) == 0);
            issue_valid  = ($urandom_range(0, 2) == 0);
            rst          = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            check("rand_fa", 64'(fa), 64'(exp_sel(ex_rs1)));
            check("rand_fb", 64'(fb), 64'(exp_sel(ex_rs2)));
            check("rand_stall", 64'(stall), 64'(exp_stall()));
            check("rand_busy", 64'(busy), 64'(exp_busy()));
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
